// File: rtl/hazard_stall_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// hazard_stall_ctrl_pkg
//   Shared constants for the D-stage hazard unit: MIPS opcode/funct codes,
//   the Tuse "register not read" marker, forwarding-select encodings, and
//   the saturating Tnew decrement used when a producer advances a stage.
// ---------------------------------------------------------------------------
package hazard_stall_ctrl_pkg;

  typedef logic [1:0] tuse_t;
  typedef logic [1:0] tnew_t;

  // Tuse value meaning "this operand is not read by the instruction".
  localparam tuse_t TUSE_NONE = 2'b11;

  // D-stage operand source selects.
  typedef enum logic [1:0] {
    FWD_GRF = 2'b00,
    FWD_M   = 2'b01,
    FWD_W   = 2'b10
  } fwd_sel_e;

  // Default mult/div latencies.
  localparam int MULT_CYC_DEF = 5;
  localparam int DIV_CYC_DEF  = 10;

  // Primary opcodes.
  localparam logic [5:0] OP_SPECIAL = 6'h00;
  localparam logic [5:0] OP_BEQ     = 6'h04;
  localparam logic [5:0] OP_ADDI    = 6'h08;
  localparam logic [5:0] OP_ADDIU   = 6'h09;
  localparam logic [5:0] OP_SLTI    = 6'h0a;
  localparam logic [5:0] OP_SLTIU   = 6'h0b;
  localparam logic [5:0] OP_ANDI    = 6'h0c;
  localparam logic [5:0] OP_ORI     = 6'h0d;
  localparam logic [5:0] OP_XORI    = 6'h0e;
  localparam logic [5:0] OP_LUI     = 6'h0f;
  localparam logic [5:0] OP_LB      = 6'h20;
  localparam logic [5:0] OP_LH      = 6'h21;
  localparam logic [5:0] OP_LW      = 6'h23;
  localparam logic [5:0] OP_LBU     = 6'h24;
  localparam logic [5:0] OP_LHU     = 6'h25;
  localparam logic [5:0] OP_SB      = 6'h28;
  localparam logic [5:0] OP_SH      = 6'h29;
  localparam logic [5:0] OP_SW      = 6'h2b;

  // SPECIAL funct codes.
  localparam logic [5:0] FN_JR    = 6'h08;
  localparam logic [5:0] FN_MFHI  = 6'h10;
  localparam logic [5:0] FN_MTHI  = 6'h11;
  localparam logic [5:0] FN_MFLO  = 6'h12;
  localparam logic [5:0] FN_MTLO  = 6'h13;
  localparam logic [5:0] FN_MULT  = 6'h18;
  localparam logic [5:0] FN_MULTU = 6'h19;
  localparam logic [5:0] FN_DIV   = 6'h1a;
  localparam logic [5:0] FN_DIVU  = 6'h1b;
  localparam logic [5:0] FN_ADD   = 6'h20;
  localparam logic [5:0] FN_ADDU  = 6'h21;
  localparam logic [5:0] FN_SUB   = 6'h22;
  localparam logic [5:0] FN_SUBU  = 6'h23;
  localparam logic [5:0] FN_AND   = 6'h24;
  localparam logic [5:0] FN_OR    = 6'h25;
  localparam logic [5:0] FN_XOR   = 6'h26;
  localparam logic [5:0] FN_NOR   = 6'h27;
  localparam logic [5:0] FN_SLT   = 6'h2a;
  localparam logic [5:0] FN_SLTU  = 6'h2b;

  // Tnew one stage later: counts down to 0 and stays there.
  function automatic tnew_t sat_dec(input tnew_t t);
    return (t == 2'b00) ? 2'b00 : t - 2'b01;
  endfunction

endpackage

// File: rtl/hazard_stall_ctrl_tuse_decode.sv
// ---------------------------------------------------------------------------
// tuse_decode
//   Combinational decode of the D-stage instruction into the cycle in which
//   each source register is first needed (Tuse), plus a flag for the
//   HI/LO-class instructions that must wait for the mult/div unit.
// Ports
//   opcode   in  6  instr[31:26]
//   funct    in  6  instr[5:0]
//   tuse_rs  out 2  Tuse of rs, TUSE_NONE if rs is not read
//   tuse_rt  out 2  Tuse of rt, TUSE_NONE if rt is not read
//   is_md    out 1  mult/multu/div/divu/mfhi/mflo/mthi/mtlo
// ---------------------------------------------------------------------------
module tuse_decode
  import hazard_stall_ctrl_pkg::*;
(
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  output tuse_t      tuse_rs,
  output tuse_t      tuse_rt,
  output logic       is_md
);

  always_comb begin
    // NOTE: every output gets a default before the case so that no path
    // leaves a value unassigned, which would otherwise infer a latch.
    tuse_rs = TUSE_NONE;
    tuse_rt = TUSE_NONE;
    is_md   = 1'b0;

    case (opcode)
      OP_SPECIAL: begin
        case (funct)
          FN_ADD, FN_ADDU, FN_SUB, FN_SUBU,
          FN_AND, FN_OR, FN_XOR, FN_NOR, FN_SLT, FN_SLTU: begin
            tuse_rs = 2'd1;
            tuse_rt = 2'd1;
          end
          FN_MULT, FN_MULTU, FN_DIV, FN_DIVU: begin
            tuse_rs = 2'd1;
            tuse_rt = 2'd1;
            is_md   = 1'b1;
          end
          FN_MTHI, FN_MTLO: begin
            tuse_rs = 2'd1;
            is_md   = 1'b1;
          end
          // mfhi/mflo read no GPR but still depend on HI/LO.
          FN_MFHI, FN_MFLO: is_md = 1'b1;
          // jr resolves its target in D.
          FN_JR: tuse_rs = 2'd0;
          default: ;
        endcase
      end
      OP_BEQ: begin
        tuse_rs = 2'd0;
        tuse_rt = 2'd0;
      end
      OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU, OP_ANDI, OP_ORI, OP_XORI, OP_LUI,
      OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU:
        tuse_rs = 2'd1;
      // Store data is only needed when the store reaches M.
      OP_SB, OP_SH, OP_SW: begin
        tuse_rs = 2'd1;
        tuse_rt = 2'd2;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/hazard_stall_ctrl.sv
// ---------------------------------------------------------------------------
// hazard_stall_ctrl
//   D-stage hazard unit. Carries the E-stage producer (Tnew, destination)
//   through a shadow M/W pipe, compares against the D instruction's Tuse to
//   decide stalls and forwarding selects, and tracks mult/div busy time so
//   HI/LO-class instructions wait in D.
// Ports
//   clk          in   1   clock
//   reset        in   1   synchronous, active-high
//   instr_d      in   32  instruction in D
//   tnew_e       in   2   Tnew of the instruction in E
//   num_new_e    in   5   destination of the instruction in E, 0 = none
//   md_start_e   in   1   mult/div issuing in E this cycle
//   md_is_div_e  in   1   1 = div/divu, 0 = mult/multu
//   stall        out  1   freeze PC/D, bubble into E
//   fwd_rs_sel   out  2   rs source: 00 GRF, 01 M, 10 W
//   fwd_rt_sel   out  2   rt source, same encoding
//   md_busy      out  1   mult/div counter non-zero
// ---------------------------------------------------------------------------
module hazard_stall_ctrl
  import hazard_stall_ctrl_pkg::*;
#(
  parameter int MULT_CYC = MULT_CYC_DEF,
  parameter int DIV_CYC  = DIV_CYC_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] instr_d,
  input  logic [1:0]  tnew_e,
  input  logic [4:0]  num_new_e,
  input  logic        md_start_e,
  input  logic        md_is_div_e,
  output logic        stall,
  output logic [1:0]  fwd_rs_sel,
  output logic [1:0]  fwd_rt_sel,
  output logic        md_busy
);

  localparam int CNT_W = $clog2(DIV_CYC + 1);

  logic [4:0] rs_d;
  logic [4:0] rt_d;
  tuse_t      tuse_rs;
  tuse_t      tuse_rt;
  logic       is_md;

  // Immediate/shamt bits play no part in hazard detection.
  logic       unused_instr_bits;

  tnew_t      tnew_m_q, tnew_m_d;
  logic [4:0] num_m_q,  num_m_d;
  logic [4:0] num_w_q,  num_w_d;
  logic [CNT_W-1:0] md_cnt_q, md_cnt_d;

  logic stall_rs;
  logic stall_rt;
  logic stall_md;

  assign rs_d              = instr_d[25:21];
  assign rt_d              = instr_d[20:16];
  assign unused_instr_bits = ^instr_d[15:6];

  tuse_decode u_tuse_decode (
    .opcode  (instr_d[31:26]),
    .funct   (instr_d[5:0]),
    .tuse_rs (tuse_rs),
    .tuse_rt (tuse_rt),
    .is_md   (is_md)
  );

  // Next state. The shadow pipe advances every cycle, stalls included:
  // while stalled, E carries a bubble with num_new_e = 0.
  always_comb begin
    tnew_m_d = sat_dec(tnew_e);
    num_m_d  = num_new_e;
    num_w_d  = num_m_q;

    md_cnt_d = md_cnt_q;
    if (md_start_e) begin
      md_cnt_d = md_is_div_e ? CNT_W'(DIV_CYC) : CNT_W'(MULT_CYC);
    end else if (md_cnt_q != '0) begin
      md_cnt_d = md_cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every flop
    // samples its _d value from the same pre-edge snapshot.
    // NOTE: reset is synchronous; it only takes effect on a clock edge.
    if (reset) begin
      tnew_m_q <= '0;
      num_m_q  <= '0;
      num_w_q  <= '0;
      md_cnt_q <= '0;
    end else begin
      tnew_m_q <= tnew_m_d;
      num_m_q  <= num_m_d;
      num_w_q  <= num_w_d;
      md_cnt_q <= md_cnt_d;
    end
  end

  // A producer stalls the reader if its result is still further away than
  // the reader's deadline. Register 0 is never a real dependency.
  function automatic logic data_hazard(input logic [4:0] r, input tuse_t tuse);
    logic hit_e;
    logic hit_m;
    hit_e = (num_new_e == r) && (tnew_e > tuse);
    hit_m = (num_m_q == r) && (tnew_m_q > tuse);
    return (r != 5'd0) && (tuse != TUSE_NONE) && (hit_e || hit_m);
  endfunction

  // M only forwards once its value is ready; W always holds a final value.
  function automatic fwd_sel_e fwd_select(input logic [4:0] r);
    fwd_sel_e sel;
    sel = FWD_GRF;
    if (r != 5'd0) begin
      if ((num_m_q == r) && (tnew_m_q == 2'd0)) begin
        sel = FWD_M;
      end else if (num_w_q == r) begin
        sel = FWD_W;
      end
    end
    return sel;
  endfunction

  always_comb begin
    stall_rs = data_hazard(rs_d, tuse_rs);
    stall_rt = data_hazard(rt_d, tuse_rt);
    // The start cycle counts as busy: the counter has not loaded yet.
    stall_md = is_md && ((md_cnt_q != '0) || md_start_e);

    stall      = stall_rs || stall_rt || stall_md;
    fwd_rs_sel = fwd_select(rs_d);
    fwd_rt_sel = fwd_select(rt_d);
    md_busy    = (md_cnt_q != '0);
  end

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// ---------------------------------------------------------------------------
// tb_hazard_stall_ctrl
//   Directed scenarios with literal expectations, then randomized traffic.
//   A history-based model (per-cycle record of E producers, starts and
//   resets) derives the expected outputs for every non-reset cycle.
// ---------------------------------------------------------------------------
module tb_hazard_stall_ctrl;

  localparam int MAXC    = 4096;
  localparam int DIV_LEN = 10;
  localparam int MUL_LEN = 5;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] instr_d;
  logic [1:0]  tnew_e;
  logic [4:0]  num_new_e;
  logic        md_start_e;
  logic        md_is_div_e;
  logic        stall;
  logic [1:0]  fwd_rs_sel;
  logic [1:0]  fwd_rt_sel;
  logic        md_busy;

  hazard_stall_ctrl #(.MULT_CYC(MUL_LEN), .DIV_CYC(DIV_LEN)) dut (
    .clk         (clk),
    .reset       (reset),
    .instr_d     (instr_d),
    .tnew_e      (tnew_e),
    .num_new_e   (num_new_e),
    .md_start_e  (md_start_e),
    .md_is_div_e (md_is_div_e),
    .stall       (stall),
    .fwd_rs_sel  (fwd_rs_sel),
    .fwd_rt_sel  (fwd_rt_sel),
    .md_busy     (md_busy)
  );

  always #5 clk = ~clk;

  typedef enum int {
    K_ADD, K_SUBU, K_OR, K_SLT, K_ADDI, K_ORI, K_LUI, K_LW, K_LB,
    K_SW, K_SH, K_SB, K_BEQ, K_JR, K_MULT, K_DIVU, K_MFHI, K_MFLO,
    K_MTHI, K_MTLO, K_NOP, K_BAD_OP, K_BAD_FN, K_COUNT
  } kind_e;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  bit chk_en  = 1'b0;

  // Per-cycle history, indexed by cycle number.
  int h_num  [MAXC];
  int h_tnew [MAXC];
  int h_rs   [MAXC];
  int h_rt   [MAXC];
  int h_trs  [MAXC];
  int h_trt  [MAXC];
  bit h_md   [MAXC];
  bit h_start[MAXC];
  int h_len  [MAXC];
  bit h_reset[MAXC];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  // Instruction builder with the Tuse table written out per instruction.
  function automatic void make_instr(input int k, input logic [4:0] rs, input logic [4:0] rt,
                                     output logic [31:0] ins, output int tu_rs,
                                     output int tu_rt, output bit md);
    ins = 32'h0; tu_rs = 3; tu_rt = 3; md = 1'b0;
    case (k)
      K_ADD:    begin ins = {6'h00, rs, rt, 5'd9, 5'd0, 6'h20}; tu_rs = 1; tu_rt = 1; end
      K_SUBU:   begin ins = {6'h00, rs, rt, 5'd9, 5'd0, 6'h23}; tu_rs = 1; tu_rt = 1; end
      K_OR:     begin ins = {6'h00, rs, rt, 5'd9, 5'd0, 6'h25}; tu_rs = 1; tu_rt = 1; end
      K_SLT:    begin ins = {6'h00, rs, rt, 5'd9, 5'd0, 6'h2a}; tu_rs = 1; tu_rt = 1; end
      K_ADDI:   begin ins = {6'h08, rs, rt, 16'h0004}; tu_rs = 1; end
      K_ORI:    begin ins = {6'h0d, rs, rt, 16'h00ff}; tu_rs = 1; end
      K_LUI:    begin ins = {6'h0f, 5'd0, rt, 16'h1234}; tu_rs = 1; end
      K_LW:     begin ins = {6'h23, rs, rt, 16'h0010}; tu_rs = 1; end
      K_LB:     begin ins = {6'h20, rs, rt, 16'h0001}; tu_rs = 1; end
      K_SW:     begin ins = {6'h2b, rs, rt, 16'h0000}; tu_rs = 1; tu_rt = 2; end
      K_SH:     begin ins = {6'h29, rs, rt, 16'h0002}; tu_rs = 1; tu_rt = 2; end
      K_SB:     begin ins = {6'h28, rs, rt, 16'h0003}; tu_rs = 1; tu_rt = 2; end
      K_BEQ:    begin ins = {6'h04, rs, rt, 16'h0008}; tu_rs = 0; tu_rt = 0; end
      K_JR:     begin ins = {6'h00, rs, 15'd0, 6'h08}; tu_rs = 0; end
      K_MULT:   begin ins = {6'h00, rs, rt, 10'd0, 6'h18}; tu_rs = 1; tu_rt = 1; md = 1'b1; end
      K_DIVU:   begin ins = {6'h00, rs, rt, 10'd0, 6'h1b}; tu_rs = 1; tu_rt = 1; md = 1'b1; end
      K_MFHI:   begin ins = {6'h00, 10'd0, 5'd9, 5'd0, 6'h10}; md = 1'b1; end
      K_MFLO:   begin ins = {6'h00, 10'd0, 5'd9, 5'd0, 6'h12}; md = 1'b1; end
      K_MTHI:   begin ins = {6'h00, rs, 15'd0, 6'h11}; tu_rs = 1; md = 1'b1; end
      K_MTLO:   begin ins = {6'h00, rs, 15'd0, 6'h13}; tu_rs = 1; md = 1'b1; end
      K_BAD_OP: begin ins = {6'h3f, rs, rt, 16'h1234}; end
      K_BAD_FN: begin ins = {6'h00, rs, rt, 10'd0, 6'h3f}; end
      default:  begin ins = 32'h0; end
    endcase
  endfunction

  // One clock of stimulus; records everything the model needs.
  task automatic drive(input int k, input logic [4:0] rs, input logic [4:0] rt,
                       input logic [1:0] tn, input logic [4:0] num,
                       input bit st, input bit dv, input bit rst);
    logic [31:0] ins;
    int tu_rs, tu_rt;
    bit md;
    @(posedge clk);
    #1;
    cyc++;
    make_instr(k, rs, rt, ins, tu_rs, tu_rt, md);
    instr_d     = ins;
    tnew_e      = tn;
    num_new_e   = num;
    md_start_e  = st;
    md_is_div_e = dv;
    reset       = rst;
    h_num[cyc]   = int'(num);
    h_tnew[cyc]  = int'(tn);
    h_rs[cyc]    = int'(ins[25:21]);
    h_rt[cyc]    = int'(ins[20:16]);
    h_trs[cyc]   = tu_rs;
    h_trt[cyc]   = tu_rt;
    h_md[cyc]    = md;
    h_start[cyc] = st;
    h_len[cyc]   = dv ? DIV_LEN : MUL_LEN;
    h_reset[cyc] = rst;
    chk_en       = 1'b1;
  endtask

  task automatic bubble();
    drive(K_NOP, 5'd0, 5'd0, 2'd0, 5'd0, 1'b0, 1'b0, 1'b0);
  endtask

  // Hand-computed expectations for the current cycle.
  task automatic lit(input string name, input bit s, input int frs, input int frt, input bit b);
    @(negedge clk);
    check({name, ".stall"},  32'(stall),      32'(s));
    check({name, ".fwd_rs"}, 32'(fwd_rs_sel), frs);
    check({name, ".fwd_rt"}, 32'(fwd_rt_sel), frt);
    check({name, ".busy"},   32'(md_busy),    32'(b));
  endtask

  // Busy: the most recent start before cycle c, not cut off by a reset,
  // keeps the unit busy for its length in the cycles that follow it.
  function automatic bit model_busy(input int c);
    for (int s = c - 1; s >= 1 && s >= c - DIV_LEN; s--) begin
      if (h_reset[s]) return 1'b0;
      if (h_start[s]) return (c <= s + h_len[s]);
    end
    return 1'b0;
  endfunction

  function automatic bit model_hz(input int r, input int tu, input int e_num, input int e_tn,
                                  input int m_num, input int m_tn);
    if (r == 0 || tu == 3) return 1'b0;
    return (e_num == r && e_tn > tu) || (m_num == r && m_tn > tu);
  endfunction

  function automatic int model_fwd(input int r, input int m_num, input int m_tn, input int w_num);
    if (r == 0) return 0;
    if (m_num == r && m_tn == 0) return 1;
    if (w_num == r) return 2;
    return 0;
  endfunction

  // Compare process: every non-reset cycle against the history model.
  always @(negedge clk) begin
    if (chk_en && cyc >= 3 && !h_reset[cyc]) begin
      int c, m_num, m_tn, w_num;
      bit exp_stall, busy;
      c     = cyc;
      m_num = h_reset[c-1] ? 0 : h_num[c-1];
      m_tn  = h_reset[c-1] ? 0 : ((h_tnew[c-1] > 0) ? h_tnew[c-1] - 1 : 0);
      w_num = (h_reset[c-1] || h_reset[c-2]) ? 0 : h_num[c-2];
      busy  = model_busy(c);
      exp_stall = model_hz(h_rs[c], h_trs[c], h_num[c], h_tnew[c], m_num, m_tn) ||
                  model_hz(h_rt[c], h_trt[c], h_num[c], h_tnew[c], m_num, m_tn) ||
                  (h_md[c] && (busy || h_start[c]));
      check("model.stall",  32'(stall),      32'(exp_stall));
      check("model.fwd_rs", 32'(fwd_rs_sel), model_fwd(h_rs[c], m_num, m_tn, w_num));
      check("model.fwd_rt", 32'(fwd_rt_sel), model_fwd(h_rt[c], m_num, m_tn, w_num));
      check("model.busy",   32'(md_busy),    32'(busy));
    end
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; instr_d = '0; tnew_e = '0; num_new_e = '0;
    md_start_e = 1'b0; md_is_div_e = 1'b0;
    h_reset[0] = 1'b1;

    drive(K_NOP, 5'd0, 5'd0, 2'd0, 5'd0, 1'b0, 1'b0, 1'b1);
    drive(K_NOP, 5'd0, 5'd0, 2'd0, 5'd0, 1'b0, 1'b0, 1'b1);
    bubble(); lit("reset_state", 1'b0, 0, 0, 1'b0);

    // Load-use: lw $8 in E, add $9,$8,$1 in D.
    bubble(); bubble();
    drive(K_ADD, 5'd8, 5'd1, 2'd2, 5'd8, 1'b0, 1'b0, 1'b0); lit("lw_add.e",  1'b1, 0, 0, 1'b0);
    drive(K_ADD, 5'd8, 5'd1, 2'd0, 5'd0, 1'b0, 1'b0, 1'b0); lit("lw_add.m",  1'b0, 0, 0, 1'b0);
    drive(K_ADD, 5'd8, 5'd1, 2'd0, 5'd0, 1'b0, 1'b0, 1'b0); lit("lw_add.w",  1'b0, 2, 0, 1'b0);

    // addi $5 then beq $5,$0.
    bubble(); bubble();
    drive(K_BEQ, 5'd5, 5'd0, 2'd1, 5'd5, 1'b0, 1'b0, 1'b0); lit("addi_beq.e", 1'b1, 0, 0, 1'b0);
    drive(K_BEQ, 5'd5, 5'd0, 2'd0, 5'd0, 1'b0, 1'b0, 1'b0); lit("addi_beq.m", 1'b0, 1, 0, 1'b0);

    // lw $3 then sw $3,0($4): store data is late enough, no stall.
    bubble(); bubble();
    drive(K_SW, 5'd4, 5'd3, 2'd2, 5'd3, 1'b0, 1'b0, 1'b0); lit("lw_sw.e", 1'b0, 0, 0, 1'b0);
    drive(K_SW, 5'd4, 5'd3, 2'd0, 5'd0, 1'b0, 1'b0, 1'b0); lit("lw_sw.m", 1'b0, 0, 0, 1'b0);
    drive(K_SW, 5'd4, 5'd3, 2'd0, 5'd0, 1'b0, 1'b0, 1'b0); lit("lw_sw.w", 1'b0, 0, 2, 1'b0);
    bubble(); bubble();
    drive(K_NOP, 5'd0, 5'd0, 2'd1, 5'd3, 1'b0, 1'b0, 1'b0); lit("alu_sw.e", 1'b0, 0, 0, 1'b0);
    drive(K_SW, 5'd4, 5'd3, 2'd0, 5'd0, 1'b0, 1'b0, 1'b0);  lit("alu_sw.m", 1'b0, 0, 1, 1'b0);

    // ori $0 then add $2,$0,$0: never a dependency.
    bubble(); bubble();
    drive(K_ADD, 5'd0, 5'd0, 2'd1, 5'd0, 1'b0, 1'b0, 1'b0); lit("zero.e", 1'b0, 0, 0, 1'b0);
    drive(K_ADD, 5'd0, 5'd0, 2'd0, 5'd0, 1'b0, 1'b0, 1'b0); lit("zero.m", 1'b0, 0, 0, 1'b0);
    drive(K_ADD, 5'd0, 5'd0, 2'd0, 5'd0, 1'b0, 1'b0, 1'b0); lit("zero.w", 1'b0, 0, 0, 1'b0);

    // div start with mflo waiting in D: start cycle + 10 busy cycles.
    bubble(); bubble();
    drive(K_MFLO, 5'd0, 5'd0, 2'd0, 5'd0, 1'b1, 1'b1, 1'b0); lit("div.start", 1'b1, 0, 0, 1'b0);
    for (int i = 1; i <= DIV_LEN; i++) begin
      drive(K_MFLO, 5'd0, 5'd0, 2'd0, 5'd0, 1'b0, 1'b0, 1'b0);
      lit($sformatf("div.busy%0d", i), 1'b1, 0, 0, 1'b1);
    end
    drive(K_MFLO, 5'd0, 5'd0, 2'd0, 5'd0, 1'b0, 1'b0, 1'b0); lit("div.done", 1'b0, 0, 0, 1'b0);

    // mult issued three cycles into a div reloads the count to 5.
    drive(K_NOP, 5'd0, 5'd0, 2'd0, 5'd0, 1'b1, 1'b1, 1'b0); lit("reload.t0", 1'b0, 0, 0, 1'b0);
    bubble(); lit("reload.t1", 1'b0, 0, 0, 1'b1);
    bubble(); lit("reload.t2", 1'b0, 0, 0, 1'b1);
    drive(K_NOP, 5'd0, 5'd0, 2'd0, 5'd0, 1'b1, 1'b0, 1'b0); lit("reload.t3", 1'b0, 0, 0, 1'b1);
    for (int i = 1; i <= MUL_LEN; i++) begin
      bubble(); lit($sformatf("reload.m%0d", i), 1'b0, 0, 0, 1'b1);
    end
    bubble(); lit("reload.done", 1'b0, 0, 0, 1'b0);

    // Reset with md_cnt=7 and a load in M.
    drive(K_NOP, 5'd0, 5'd0, 2'd0, 5'd0, 1'b1, 1'b1, 1'b0);
    bubble(); bubble();
    drive(K_NOP, 5'd0, 5'd0, 2'd2, 5'd8, 1'b0, 1'b0, 1'b0);
    drive(K_ADD, 5'd8, 5'd8, 2'd0, 5'd0, 1'b0, 1'b0, 1'b1);
    drive(K_ADD, 5'd8, 5'd8, 2'd0, 5'd0, 1'b0, 1'b0, 1'b0); lit("midreset.a", 1'b0, 0, 0, 1'b0);
    drive(K_MFLO, 5'd0, 5'd0, 2'd0, 5'd0, 1'b0, 1'b0, 1'b0); lit("midreset.b", 1'b0, 0, 0, 1'b0);

    // Randomized traffic, small register set to provoke collisions.
    for (int n = 0; n < 2500; n++) begin
      int k;
      logic [4:0] rs, rt, num;
      logic [1:0] tn;
      bit st, dv, rst;
      k   = int'($urandom_range(0, K_COUNT - 1));
      rs  = 5'($urandom_range(0, 7));
      rt  = 5'($urandom_range(0, 7));
      tn  = 2'($urandom_range(0, 2));
      num = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(1, 7));
      st  = ($urandom_range(0, 9) == 0);
      dv  = $urandom_range(0, 1) == 1;
      rst = ($urandom_range(0, 299) == 0);
      drive(k, rs, rt, tn, num, st, dv, rst);
    end

    @(negedge clk);
    #1;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
